fp_addsub_pipe: RTL and testbench
=================================

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa field width. The word width is W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1  operand pair and op present.
REQ-006 SHALL have port in_ready  out  1  block accepts the input this cycle.
REQ-007 SHALL have ports a and b  in  W  IEEE-754-format operands.
REQ-008 SHALL have port op  in  1  0 = a+b, 1 = a-b.
REQ-009 SHALL have port out_valid  out  1  result and flags present.
REQ-010 SHALL have port out_ready  in  1  consumer takes the result this cycle.
REQ-011 SHALL have port result  out  W  rounded sum/difference.
REQ-012 SHALL have port flags  out  4  {invalid, overflow, underflow, inexact}.

Function
REQ-013 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-014 SHALL be a 3-stage pipeline: S1 unpack/classify/swap/align, S2 signed mantissa add/sub plus leading-zero count, S3 normalise/round/pack. Latency SHALL be 3 cycles from accept to out_valid when unstalled.
REQ-015 SHALL use a global advance enable en = !out_valid || out_ready, with in_ready = en. Throughput SHALL be 1 per cycle when out_ready is held high.
REQ-016 SHALL hold result, flags and out_valid stable while out_valid && !out_ready. No result SHALL be dropped or duplicated.
REQ-017 SHALL apply op by inverting the sign of b before classification.
REQ-018 SHALL flush subnormal inputs to signed zero. Any result below the minimum normal SHALL flush to signed zero with underflow=1 and inexact=1.
REQ-019 SHALL select the larger-magnitude operand as the base, using exponent then mantissa.
REQ-020 SHALL right-shift the smaller mantissa, with guard, round and sticky bits. Shift amounts ≥ MAN_W+3 SHALL collapse the operand into sticky.
REQ-021 SHALL perform an effective subtraction when the signs differ. The result sign SHALL be the sign of the larger-magnitude operand.
REQ-022 SHALL round to nearest, ties to even. The mantissa carry-out from rounding SHALL increment the exponent.
REQ-023 SHALL set inexact whenever guard|round|sticky is nonzero after normalisation.
REQ-024 SHALL return +0 for an exact-zero result of differing-sign operands. (-0)+(-0) SHALL return -0.
REQ-025 SHALL return canonical quiet NaN (sign 0, exponent all-ones, mantissa MSB 1, rest 0) with invalid=1 in two cases: any NaN input, or inf + (-inf) after op is applied.
REQ-026 SHALL propagate a single infinity, or same-signed infinities, unchanged, with all flags 0.
REQ-027 SHALL return signed infinity with overflow=1 and inexact=1 when the rounded exponent reaches all-ones.
REQ-028 SHALL set flags only from the associated operation, never sticky across operations.

Reset
REQ-029 SHALL clear out_valid and all stage valid bits on rst, dropping in-flight operations.
REQ-030 SHALL drive result=0 and flags=0 after reset.
REQ-031 SHALL have in_ready=1 in the cycle after rst deasserts.
REQ-032 SHALL give rst priority over the advance enable. An input presented during rst SHALL NOT be accepted.

Structure
REQ-033 SHALL take its default widths, the flag bit positions, and a canonical-NaN constant function of EXP_W/MAN_W from the shared package fp_pkg.
REQ-034 SHALL instantiate one sub-module, fp_lzc (parametrised leading-zero counter), in S2.
REQ-035 SHALL use no multi-cycle state machine; pipeline valid bits are the only control state.

Verification
REQ-036 SHALL cover: 0x3F800000 + 0x3F800000, op=0, out_ready=1 -> 0x40000000 with flags 0, out_valid 3 cycles after accept.
REQ-037 SHALL cover: 0x3F800000 - 0x3F800000 (op=1) -> 0x00000000; 0x80000000 + 0x80000000 -> 0x80000000.
REQ-038 SHALL cover: 0x7F800000 + 0xFF800000 -> 0x7FC00000 with invalid=1; 0x7FC00001 + 0x3F800000 -> 0x7FC00000 with invalid=1.
REQ-039 SHALL cover: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 with overflow=1 and inexact=1; 0x3F800000 + 0x33800000 (tie) -> 0x3F800000 with inexact=1.
REQ-040 SHALL cover backpressure: 5 back-to-back inputs with out_ready low for 4 cycles -> in_ready falls once 3 are in flight, then all 5 results emerge in order and unchanged.
REQ-041 SHALL cover reset mid-stream: rst asserted with 3 operations in flight -> out_valid=0 next cycle and none of the 3 results ever appears.

Source files
------------

// File: rtl/fp_pkg.sv
// ============================================================================
// Module : fp_pkg
// Brief  : Shared floating-point widths, flag bit positions and canonical NaN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    // flags = {invalid, overflow, underflow, inexact}
    localparam int FLAG_W         = 4;
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    // Quiet NaN: sign 0, exponent all-ones, mantissa MSB set, rest clear.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_lzc.sv
// ============================================================================
// Module : fp_lzc
// Brief  : Parametrised leading-zero counter; an all-zero input yields WIDTH.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fp_lzc #(
    parameter  int WIDTH = 28,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scanning upward lets the most significant set bit win.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_addsub_pipe.sv
// ============================================================================
// Module : fp_addsub_pipe
// Brief  : 3-stage IEEE-754 style adder/subtractor, RNE, flush-to-zero.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W = FP_EXP_W,
    parameter  int MAN_W = FP_MAN_W,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    input  logic              op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      result,
    output logic [FLAG_W-1:0] flags
);

    localparam int SW  = MAN_W + 4;          // hidden bit + mantissa + G/R/S
    localparam int NW  = SW + 1;             // plus carry-out
    localparam int LZW = $clog2(NW + 1);
    localparam int EW  = EXP_W + 2;          // signed exponent headroom

    localparam logic [EXP_W-1:0] C_EXP_MAX = {EXP_W{1'b1}};
    localparam logic [W-1:0]     C_QNAN    = W'(fp_qnan(EXP_W, MAN_W));

    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_ma, w_mb;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic [MAN_W:0]   w_sig_a, w_sig_b;

    assign w_sa = a[W-1];
    assign w_sb = b[W-1] ^ op;
    assign w_ea = a[W-2:MAN_W];
    assign w_eb = b[W-2:MAN_W];
    assign w_ma = a[MAN_W-1:0];
    assign w_mb = b[MAN_W-1:0];

    assign w_a_nan = (w_ea == C_EXP_MAX) && (w_ma != '0);
    assign w_b_nan = (w_eb == C_EXP_MAX) && (w_mb != '0);
    assign w_a_inf = (w_ea == C_EXP_MAX) && (w_ma == '0);
    assign w_b_inf = (w_eb == C_EXP_MAX) && (w_mb == '0);
    // Subnormals have a zero exponent and are treated as zero.
    assign w_sig_a = (w_ea == '0) ? '0 : {1'b1, w_ma};
    assign w_sig_b = (w_eb == '0) ? '0 : {1'b1, w_mb};

    logic              w_special;
    logic [W-1:0]      w_spec_res;
    logic [FLAG_W-1:0] w_spec_flags;

    always_comb begin
        w_special    = w_a_nan || w_b_nan || w_a_inf || w_b_inf;
        w_spec_flags = '0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
            w_spec_res                 = C_QNAN;
            w_spec_flags[FLAG_INVALID] = 1'b1;
        end else if (w_a_inf) begin
            w_spec_res = {w_sa, C_EXP_MAX, {MAN_W{1'b0}}};
        end else begin
            w_spec_res = {w_sb, C_EXP_MAX, {MAN_W{1'b0}}};
        end
    end

    logic             w_a_ge_b;
    logic             w_sign_big;
    logic [EXP_W-1:0] w_exp_big, w_exp_small, w_diff;
    logic [MAN_W:0]   w_sig_big, w_sig_small;
    logic [SW-1:0]    w_small_ext, w_shifted, w_aligned;
    logic             w_lost;

    assign w_a_ge_b = {w_ea, w_sig_a} >= {w_eb, w_sig_b};

    always_comb begin
        if (w_a_ge_b) begin
            w_sign_big  = w_sa;
            w_exp_big   = w_ea;
            w_sig_big   = w_sig_a;
            w_exp_small = w_eb;
            w_sig_small = w_sig_b;
        end else begin
            w_sign_big  = w_sb;
            w_exp_big   = w_eb;
            w_sig_big   = w_sig_b;
            w_exp_small = w_ea;
            w_sig_small = w_sig_a;
        end
    end

    assign w_diff      = w_exp_big - w_exp_small;
    assign w_small_ext = {w_sig_small, 3'b000};
    assign w_shifted   = w_small_ext >> w_diff;
    assign w_lost      = ((w_shifted << w_diff) != w_small_ext);

    always_comb begin
        if (int'(w_diff) >= SW - 1) begin
            w_aligned = {{(SW-1){1'b0}}, |w_sig_small};
        end else begin
            w_aligned = w_shifted | {{(SW-1){1'b0}}, w_lost};
        end
    end

    logic              r1_valid, r1_special, r1_sign, r1_sub;
    logic [W-1:0]      r1_spec_res;
    logic [FLAG_W-1:0] r1_spec_flags;
    logic [EXP_W-1:0]  r1_exp;
    logic [SW-1:0]     r1_big, r1_small;

    always_ff @(posedge clk) begin
        if (w_en) begin
            r1_special    <= w_special;
            r1_spec_res   <= w_spec_res;
            r1_spec_flags <= w_spec_flags;
            r1_sign       <= w_sign_big;
            r1_sub        <= (w_sa != w_sb);
            r1_exp        <= w_exp_big;
            r1_big        <= {w_sig_big, 3'b000};
            r1_small      <= w_aligned;
        end
    end

    // ---------------- S2: add/sub, leading-zero count ----------------
    logic [NW-1:0]  w_sum;
    logic [LZW-1:0] w_lzc;

    // The base is never smaller than the aligned operand, so no borrow out.
    assign w_sum = r1_sub ? ({1'b0, r1_big} - {1'b0, r1_small})
                          : ({1'b0, r1_big} + {1'b0, r1_small});

    fp_lzc #(
        .WIDTH (NW)
    ) u_lzc (
        .value (w_sum),
        .count (w_lzc)
    );

    logic              r2_valid, r2_special, r2_sign, r2_sub;
    logic [W-1:0]      r2_spec_res;
    logic [FLAG_W-1:0] r2_spec_flags;
    logic [EXP_W-1:0]  r2_exp;
    logic [NW-1:0]     r2_sum;
    logic [LZW-1:0]    r2_lzc;

    always_ff @(posedge clk) begin
        if (w_en) begin
            r2_special    <= r1_special;
            r2_spec_res   <= r1_spec_res;
            r2_spec_flags <= r1_spec_flags;
            r2_sign       <= r1_sign;
            r2_sub        <= r1_sub;
            r2_exp        <= r1_exp;
            r2_sum        <= w_sum;
            r2_lzc        <= w_lzc;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [LZW-1:0]       w_lz;
    logic [SW-1:0]        w_norm;
    logic signed [EW-1:0] w_exp_n, w_exp_r;
    logic                 w_g, w_r, w_s, w_rnd_up, w_inexact;
    logic [MAN_W+1:0]     w_m_r;
    logic [W-1:0]         w_res;
    logic [FLAG_W-1:0]    w_flags;

    assign w_lz = r2_lzc - LZW'(1);

    always_comb begin
        if (r2_sum[NW-1]) begin
            w_norm    = r2_sum[NW-1:1];
            w_norm[0] = r2_sum[1] | r2_sum[0];
            w_exp_n   = $signed(EW'(r2_exp)) + $signed(EW'(1));
        end else begin
            // Bits shifted up from R/S keep their OR intact for rounding.
            w_norm  = r2_sum[SW-1:0] << w_lz;
            w_exp_n = $signed(EW'(r2_exp)) - $signed(EW'(w_lz));
        end
    end

    assign w_g       = w_norm[2];
    assign w_r       = w_norm[1];
    assign w_s       = w_norm[0];
    assign w_inexact = w_g | w_r | w_s;
    assign w_rnd_up  = w_g & (w_r | w_s | w_norm[3]);
    assign w_m_r     = {1'b0, w_norm[SW-1:3]} + (MAN_W+2)'(w_rnd_up);
    assign w_exp_r   = w_exp_n + $signed(EW'(w_m_r[MAN_W+1]));

    always_comb begin
        w_res   = {r2_sign, w_exp_r[EXP_W-1:0], w_m_r[MAN_W-1:0]};
        w_flags = '0;
        w_flags[FLAG_INEXACT] = w_inexact;
        if (r2_special) begin
            w_res   = r2_spec_res;
            w_flags = r2_spec_flags;
        end else if (r2_sum == '0) begin
            w_res   = {r2_sign & ~r2_sub, {(W-1){1'b0}}};
            w_flags = '0;
        end else if (w_exp_n[EW-1] || (w_exp_n == '0)) begin
            w_res                   = {r2_sign, {(W-1){1'b0}}};
            w_flags                 = '0;
            w_flags[FLAG_UNDERFLOW] = 1'b1;
            w_flags[FLAG_INEXACT]   = 1'b1;
        end else if (w_exp_r >= $signed(EW'(C_EXP_MAX))) begin
            w_res                  = {r2_sign, C_EXP_MAX, {MAN_W{1'b0}}};
            w_flags                = '0;
            w_flags[FLAG_OVERFLOW] = 1'b1;
            w_flags[FLAG_INEXACT]  = 1'b1;
        end
    end

    // Valid bits are the only control state; reset beats the advance enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid  <= 1'b0;
            r2_valid  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (w_en) begin
            r1_valid  <= in_valid;
            r2_valid  <= r1_valid;
            out_valid <= r2_valid;
            if (r2_valid) begin
                result <= w_res;
                flags  <= w_flags;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
// ============================================================================
// Module : tb_fp_addsub_pipe
// Brief  : Directed-vector self-checking bench for fp_addsub_pipe (FP32).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fp_addsub_pipe;

    localparam int NV = 18;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs [NV];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;

    fp_addsub_pipe #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        a  = v.a;
        b  = v.b;
        op = v.op;
    endtask

    int lat, oidx, in_idx, seen;
    bit acc;
    int bp [5] = '{0, 8, 13, 14, 15};

    initial begin
        // {a, b, op, expected result, expected {inv, ovf, unf, inx}}
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
        vecs[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
        vecs[3]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000};
        vecs[4]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
        vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
        vecs[6]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
        vecs[7]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000};
        vecs[8]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000};
        vecs[9]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000};
        vecs[10] = '{32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0000};
        vecs[11] = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
        vecs[12] = '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0011};
        vecs[13] = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
        vecs[14] = '{32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000};
        vecs[15] = '{32'h3F800000, 32'h0D800000, 1'b0, 32'h3F800000, 4'b0001};
        vecs[16] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000};
        vecs[17] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'b0101};

        repeat (3) @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 0);
        chk("reset flags", flags, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready after reset", in_ready, 1);

        // One operation at a time: latency and value.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("v%0d latency", i), lat, 3);
            chk($sformatf("v%0d result", i), result, vecs[i].res);
            chk($sformatf("v%0d flags", i), flags, vecs[i].fl);
            @(negedge clk);
        end

        // Back-to-back stream at full throughput.
        oidx = 0;
        for (int cyc = 0; cyc < NV + 8; cyc++) begin
            if (out_valid) begin
                if (oidx < NV) begin
                    chk($sformatf("stream %0d", oidx), {result, flags},
                        {vecs[oidx].res, vecs[oidx].fl});
                end
                oidx++;
            end
            if (cyc < NV) begin
                drive(vecs[cyc]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("stream count", oidx, NV);

        // Backpressure: out_ready low for the first 4 cycles.
        oidx = 0; in_idx = 0; acc = 1'b0;
        for (int cyc = 0; cyc < 40 && oidx < 5; cyc++) begin
            if (acc) in_idx++;
            out_ready = (cyc >= 4);
            if (cyc == 3) begin
                chk("bp in_ready low", in_ready, 0);
                chk("bp accepted before stall", in_idx, 3);
                chk("bp held output", {out_valid, result, flags},
                    {1'b1, vecs[bp[0]].res, vecs[bp[0]].fl});
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp out %0d", oidx), {result, flags},
                    {vecs[bp[oidx]].res, vecs[bp[oidx]].fl});
                oidx++;
            end
            if (in_idx < 5) begin
                drive(vecs[bp[in_idx]]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1 acc = in_valid && in_ready;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp output count", oidx, 5);
        repeat (2) @(negedge clk);

        // Reset with three operations in flight; input during reset ignored.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(vecs[k]);
            in_valid = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        drive(vecs[14]);
        in_valid = 1'b1;
        @(negedge clk);
        chk("rst out_valid cleared", out_valid, 0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rst in_ready after deassert", in_ready, 1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst no stale outputs", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
